img2col_layer_scheduler: RTL and testbench

IMG2COL_LAYER_SCHEDULER -- requirements
Module: img2col_layer_scheduler

---
 rtl/img2col_sched_pkg.sv | 50 +++++
 rtl/img2col_desc_ram.sv | 26 ++
 rtl/img2col_layer_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_img2col_layer_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img2col_sched_pkg.sv
// Shared definitions for the Img2Col layer scheduler: descriptor layout, FSM states
// and the repeat-count helper.
package img2col_sched_pkg;

    localparam int DESC_W = 168;
    localparam int CFG_W  = 160;

    localparam int STRIDE_LSB       = 0;
    localparam int STRIDE_W         = 8;
    localparam int KERNEL_LSB       = 8;
    localparam int KERNEL_W         = 8;
    localparam int WINDOW_LSB       = 16;
    localparam int WINDOW_W         = 8;
    localparam int SLIDING_LSB      = 24;
    localparam int SLIDING_W        = 8;
    localparam int IN_SIZE_LSB      = 32;
    localparam int IN_SIZE_W        = 16;
    localparam int IN_CH_LSB        = 48;
    localparam int IN_CH_W          = 16;
    localparam int OUT_CH_LSB       = 64;
    localparam int OUT_CH_W         = 16;
    localparam int OUT_SIZE_LSB     = 80;
    localparam int OUT_SIZE_W       = 16;
    localparam int OUTCOL_TIMES_LSB = 96;
    localparam int OUTCOL_TIMES_W   = 16;
    localparam int INCOL_TIMES_LSB  = 112;
    localparam int INCOL_TIMES_W    = 16;
    localparam int OUTROW_TIMES_LSB = 128;
    localparam int OUTROW_TIMES_W   = 16;
    localparam int OCH_TIMES_LSB    = 144;
    localparam int OCH_TIMES_W      = 16;
    localparam int REPEAT_LSB       = 160;
    localparam int REPEAT_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // A zero repeat field still runs the layer once.
    function automatic logic [REPEAT_W-1:0] eff_repeat(input logic [REPEAT_W-1:0] r);
        return (r == '0) ? REPEAT_W'(1) : r;
    endfunction

endpackage

// File: rtl/img2col_desc_ram.sv
// Descriptor table: one write port, one synchronous read port, no reset on contents.
module img2col_desc_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 168
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/img2col_layer_scheduler.sv
// Walks the descriptor table layer by layer: load config, clear datapath FIFOs, then
// pulse img_start once per repeat and wait for img_mlast, with a RUN watchdog.
module img2col_layer_scheduler
    import img2col_sched_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     desc_we,
    input  logic [$clog2(DEPTH)-1:0] desc_addr,
    input  logic [DESC_W-1:0]        desc_wdata,
    input  logic [$clog2(DEPTH):0]   num_layers,
    input  logic [31:0]              timeout_limit,
    input  logic                     go,
    input  logic                     abort,
    input  logic                     img_mlast,
    output logic                     img_start,
    output logic                     fifo_clear,
    output logic [CFG_W-1:0]         cfg,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic [$clog2(DEPTH)-1:0] cur_layer
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLEAR_CYCLES + 1);

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [LW-1:0]       nl_q, nl_d;
    logic [REPEAT_W-1:0] rep_q, rep_d;
    logic [CW-1:0]       clr_q, clr_d;
    logic [31:0]         wdog_q, wdog_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic                img_start_q, img_start_d;
    logic                fifo_clear_q, fifo_clear_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                ram_we;
    logic [DESC_W-1:0]   rd_data;
    logic [LW-1:0]       nl_clamped;
    logic                abort_act;

    assign ram_we     = desc_we && (state_q == ST_IDLE);
    assign nl_clamped = (num_layers > LW'(DEPTH)) ? LW'(DEPTH) : num_layers;
    assign abort_act  = abort && (state_q != ST_IDLE);

    // Read address follows the next index so the entry is ready when LOAD is entered.
    img2col_desc_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DESC_W)
    ) u_desc_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (desc_addr),
        .wdata_i (desc_wdata),
        .raddr_i (idx_d),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nl_d    = nl_q;
        rep_d   = rep_q;
        clr_d   = clr_q;
        wdog_d  = wdog_q;
        cfg_d   = cfg_q;
        err_d   = err_q;

        if (abort_act) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        if (num_layers != '0) begin
                            nl_d    = nl_clamped;
                            idx_d   = '0;
                            err_d   = 1'b0;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    cfg_d   = rd_data[CFG_W-1:0];
                    rep_d   = eff_repeat(rd_data[REPEAT_LSB +: REPEAT_W]);
                    clr_d   = '0;
                    state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (clr_q == CW'(CLEAR_CYCLES - 1)) begin
                        state_d = ST_START;
                    end else begin
                        clr_d = clr_q + CW'(1);
                    end
                end
                ST_START: begin
                    wdog_d  = '0;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // A completed run wins over a watchdog expiring in the same cycle.
                    if (img_mlast) begin
                        if (rep_q > REPEAT_W'(1)) begin
                            rep_d   = rep_q - REPEAT_W'(1);
                            state_d = ST_START;
                        end else begin
                            state_d = ST_NEXT;
                        end
                    end else if ((timeout_limit != 32'd0) && ((wdog_q + 32'd1) >= timeout_limit)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wdog_d = wdog_q + 32'd1;
                    end
                end
                ST_NEXT: begin
                    if ({1'b0, idx_q} == (nl_q - LW'(1))) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        img_start_d  = (state_d == ST_START);
        fifo_clear_d = (state_d == ST_CLEAR);
        done_d       = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            nl_q         <= '0;
            rep_q        <= '0;
            clr_q        <= '0;
            wdog_q       <= '0;
            cfg_q        <= '0;
            img_start_q  <= 1'b0;
            fifo_clear_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            nl_q         <= nl_d;
            rep_q        <= rep_d;
            clr_q        <= clr_d;
            wdog_q       <= wdog_d;
            cfg_q        <= cfg_d;
            img_start_q  <= img_start_d;
            fifo_clear_q <= fifo_clear_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Abort silences the strobes in the very cycle it is raised.
    assign img_start   = img_start_q && !abort_act;
    assign fifo_clear  = fifo_clear_q && !abort_act;
    assign done        = done_q && !abort_act;
    assign busy        = busy_q;
    assign cfg         = cfg_q;
    assign err_timeout = err_q;
    assign cur_layer   = idx_q;

endmodule

// File: tb/tb_img2col_layer_scheduler.sv
// Directed bench for img2col_layer_scheduler; each img_start is checked against a
// scoreboard of expected configurations filled when a sequence is launched.
module tb_img2col_layer_scheduler;

    localparam int CLR = 2;

    typedef struct packed {
        logic [159:0] cfg;
        logic [2:0]   layer;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         desc_we = 1'b0;
    logic [2:0]   desc_addr = '0;
    logic [167:0] desc_wdata = '0;
    logic [3:0]   num_layers = '0;
    logic [31:0]  timeout_limit = '0;
    logic         go = 1'b0;
    logic         abort = 1'b0;
    logic         img_mlast = 1'b0;
    logic         img_start;
    logic         fifo_clear;
    logic [159:0] cfg;
    logic         busy;
    logic         done;
    logic         err_timeout;
    logic [2:0]   cur_layer;

    int           checks = 0;
    int           errors = 0;
    int           nStart = 0;
    int           nClear = 0;
    int           nDone = 0;
    int           cfgChanges = 0;
    logic [159:0] prevCfg = '0;
    logic [167:0] tbl [8];
    exp_t         sb [$];

    img2col_layer_scheduler #(
        .DEPTH        (8),
        .CLEAR_CYCLES (CLR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .desc_we       (desc_we),
        .desc_addr     (desc_addr),
        .desc_wdata    (desc_wdata),
        .num_layers    (num_layers),
        .timeout_limit (timeout_limit),
        .go            (go),
        .abort         (abort),
        .img_mlast     (img_mlast),
        .img_start     (img_start),
        .fifo_clear    (fifo_clear),
        .cfg           (cfg),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .cur_layer     (cur_layer)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [167:0] obs, input logic [167:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [167:0] mkDesc(input logic [7:0] rep);
        return {rep, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic writeDesc(input logic [2:0] addr, input logic [167:0] data);
        desc_we    = 1'b1;
        desc_addr  = addr;
        desc_wdata = data;
        tick();
        desc_we    = 1'b0;
        tbl[addr]  = data;
    endtask

    task automatic pushRun(input int layer);
        int reps;
        reps = (tbl[layer][167:160] == 8'd0) ? 1 : int'(tbl[layer][167:160]);
        for (int r = 0; r < reps; r++) begin
            sb.push_back({tbl[layer][159:0], 3'(layer)});
        end
    endtask

    task automatic applyStimulus(input logic [3:0] nl, input logic [31:0] limit);
        num_layers    = nl;
        timeout_limit = limit;
        go            = 1'b1;
        tick();
        go            = 1'b0;
    endtask

    task automatic pulseMlast();
        img_mlast = 1'b1;
        tick();
        img_mlast = 1'b0;
    endtask

    task automatic waitStart(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (img_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, 168'(seen), 168'd1);
    endtask

    task automatic waitDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, 168'(seen), 168'd1);
        @(negedge clk);
        checkOutput({tag, " done width"}, 168'(done), 168'd0);
        checkOutput({tag, " busy after done"}, 168'(busy), 168'd0);
    endtask

    task automatic serviceRun(input int starts, input int gap, input string tag);
        for (int p = 0; p < starts; p++) begin
            waitStart(tag);
            repeat (gap) tick();
            pulseMlast();
        end
        waitDone(tag);
    endtask

    // Scoreboard side: every img_start must match the oldest expected configuration.
    always @(negedge clk) begin
        exp_t e;
        if (img_start === 1'b1) begin
            nStart++;
            checkOutput("sb occupancy at img_start", 168'(sb.size() > 0), 168'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("sb cfg", 168'(cfg), 168'(e.cfg));
                checkOutput("sb cur_layer", 168'(cur_layer), 168'(e.layer));
            end
        end
        if (fifo_clear === 1'b1) nClear++;
        if (done === 1'b1) nDone++;
        if (cfg !== prevCfg) begin
            cfgChanges++;
            prevCfg = cfg;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: observed hang expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int sS, sC, sD, snapCfg, n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", 168'(busy), 168'd0);
        checkOutput("reset img_start", 168'(img_start), 168'd0);
        checkOutput("reset fifo_clear", 168'(fifo_clear), 168'd0);
        checkOutput("reset done", 168'(done), 168'd0);
        checkOutput("reset err_timeout", 168'(err_timeout), 168'd0);
        checkOutput("reset cfg", 168'(cfg), 168'd0);
        checkOutput("reset cur_layer", 168'(cur_layer), 168'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] two layers, repeat 1 then 3");
        writeDesc(3'd0, mkDesc(8'd1));
        writeDesc(3'd1, mkDesc(8'd3));
        sS = nStart; sC = nClear; sD = nDone;
        pushRun(0);
        pushRun(1);
        applyStimulus(4'd2, 32'd0);
        @(negedge clk);
        checkOutput("t1 LOAD busy", 168'(busy), 168'd1);
        checkOutput("t1 LOAD fifo_clear", 168'(fifo_clear), 168'd0);
        @(negedge clk);
        checkOutput("t1 CLEAR cycle1", 168'(fifo_clear), 168'd1);
        @(negedge clk);
        checkOutput("t1 CLEAR cycle2", 168'(fifo_clear), 168'd1);
        checkOutput("t1 no early start", 168'(img_start), 168'd0);
        @(negedge clk);
        checkOutput("t1 go-to-start latency", 168'(img_start), 168'd1);
        snapCfg = cfgChanges;
        for (int p = 0; p < 4; p++) begin
            repeat (50) tick();
            pulseMlast();
            if (p == 0) begin
                waitStart("t1 layer1 start");
            end else if (p < 3) begin
                @(negedge clk);
                checkOutput("t1 mlast-to-restart latency", 168'(img_start), 168'd1);
            end
        end
        waitDone("t1 done");
        tick();
        checkOutput("t1 start count", 168'(nStart - sS), 168'd4);
        checkOutput("t1 clear cycles", 168'(nClear - sC), 168'(2 * CLR));
        checkOutput("t1 done count", 168'(nDone - sD), 168'd1);
        checkOutput("t1 cfg changes", 168'(cfgChanges - snapCfg), 168'd1);
        checkOutput("t1 sb drained", 168'(sb.size()), 168'd0);

        $display("[TB] zero layers");
        sS = nStart; sC = nClear;
        applyStimulus(4'd0, 32'd0);
        @(negedge clk);
        checkOutput("t2 done pulse", 168'(done), 168'd1);
        @(negedge clk);
        checkOutput("t2 done one cycle", 168'(done), 168'd0);
        checkOutput("t2 idle", 168'(busy), 168'd0);
        tick();
        checkOutput("t2 no img_start", 168'(nStart - sS), 168'd0);
        checkOutput("t2 no fifo_clear", 168'(nClear - sC), 168'd0);

        $display("[TB] watchdog");
        sD = nDone;
        pushRun(0);
        applyStimulus(4'd1, 32'd100);
        waitStart("t3 start");
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) break;
            n++;
        end
        checkOutput("t3 RUN cycles before timeout", 168'(n), 168'd100);
        checkOutput("t3 err_timeout", 168'(err_timeout), 168'd1);
        checkOutput("t3 busy dropped", 168'(busy), 168'd0);
        repeat (3) tick();
        checkOutput("t3 no done", 168'(nDone - sD), 168'd0);
        checkOutput("t3 err sticky", 168'(err_timeout), 168'd1);
        timeout_limit = 32'd0;

        $display("[TB] abort with mlast");
        sD = nDone;
        pushRun(0);
        applyStimulus(4'd2, 32'd0);
        waitStart("t4 start");
        checkOutput("t4 err cleared by go", 168'(err_timeout), 168'd0);
        repeat (5) tick();
        sS = nStart;
        img_mlast = 1'b1;
        abort     = 1'b1;
        tick();
        img_mlast = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        checkOutput("t4 idle after abort", 168'(busy), 168'd0);
        repeat (60) tick();
        checkOutput("t4 no further start", 168'(nStart - sS), 168'd0);
        checkOutput("t4 no done", 168'(nDone - sD), 168'd0);
        checkOutput("t4 sb drained", 168'(sb.size()), 168'd0);

        $display("[TB] abort during clear");
        applyStimulus(4'd1, 32'd0);
        tick();
        abort = 1'b1;
        #1;
        checkOutput("t4b fifo_clear forced low", 168'(fifo_clear), 168'd0);
        checkOutput("t4b still busy", 168'(busy), 168'd1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        checkOutput("t4b idle", 168'(busy), 168'd0);

        $display("[TB] table write while busy");
        pushRun(0);
        applyStimulus(4'd1, 32'd0);
        waitStart("t5 start");
        desc_we    = 1'b1;
        desc_addr  = 3'd0;
        desc_wdata = mkDesc(8'd1);
        tick();
        desc_we    = 1'b0;
        @(negedge clk);
        checkOutput("t5 cfg held", 168'(cfg), 168'(tbl[0][159:0]));
        repeat (3) tick();
        pulseMlast();
        waitDone("t5 done");
        pushRun(0);
        applyStimulus(4'd1, 32'd0);
        serviceRun(1, 4, "t5 rerun");
        checkOutput("t5 sb drained", 168'(sb.size()), 168'd0);

        $display("[TB] reset mid-clear");
        applyStimulus(4'd1, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("t6 in CLEAR", 168'(fifo_clear), 168'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 async fifo_clear", 168'(fifo_clear), 168'd0);
        checkOutput("t6 async busy", 168'(busy), 168'd0);
        checkOutput("t6 async cfg", 168'(cfg), 168'd0);
        checkOutput("t6 async cur_layer", 168'(cur_layer), 168'd0);
        checkOutput("t6 async done", 168'(done), 168'd0);
        tick();
        rst_n = 1'b1;
        tick();
        writeDesc(3'd0, mkDesc(8'd2));
        sS = nStart;
        pushRun(0);
        applyStimulus(4'd1, 32'd0);
        serviceRun(2, 5, "t6 restart");
        checkOutput("t6 restart starts", 168'(nStart - sS), 168'd2);

        $display("[TB] num_layers clamp");
        for (int i = 0; i < 8; i++) begin
            writeDesc(3'(i), mkDesc((i % 2 == 1) ? 8'd0 : 8'd1));
        end
        sS = nStart;
        for (int i = 0; i < 8; i++) begin
            pushRun(i);
        end
        applyStimulus(4'd15, 32'd0);
        serviceRun(8, 3, "t7 clamp");
        tick();
        checkOutput("t7 clamp starts", 168'(nStart - sS), 168'd8);
        checkOutput("t7 sb drained", 168'(sb.size()), 168'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
